// File: rtl/mono_data_tx.sv
// Purpose: buffers hit words and serialises them MSB-first on DATA when the receiver raises READ under FREEZE.
// Latency: the edge that sees READ rise moves to LOAD, the next edge loads the head word, and its MSB is on DATA in the following cycle.
// Backpressure: none upstream; hits arriving while the buffer is full are dropped and counted in LOST_CNT.
module mono_data_tx #(
    parameter int DATA_WIDTH = 26,
    parameter int DEPTH      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  HIT_WR,
    input  logic [DATA_WIDTH-1:0] HIT_DATA,
    input  logic                  READ,
    input  logic                  FREEZE,
    output logic                  TOKEN,
    output logic                  DATA,
    output logic                  HIT_FULL,
    output logic [7:0]            LOST_CNT,
    output logic                  BUSY
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           occ;
    logic [AW:0]           occ_next;
    state_t                state;
    logic                  read_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  read_req;
    logic                  do_pop;
    logic                  do_push;
    logic                  do_drop;

    // A pop in LOAD frees a slot first, so a simultaneous push into a full buffer still lands.
    assign read_req  = READ & ~read_q;
    assign do_pop    = (state == LOAD) && (occ != '0);
    assign do_push   = !RST && EN && HIT_WR && ((occ != OCC_FULL) || do_pop);
    assign do_drop   = EN && HIT_WR && (occ == OCC_FULL) && !do_pop;
    assign load_word = do_pop ? mem[rd_ptr] : '0;

    // Next occupancy: push and pop together cancel out.
    always_comb begin
        occ_next = occ;
        if (do_push && !do_pop)
            occ_next = occ + OCC_ONE;
        else if (do_pop && !do_push)
            occ_next = occ - OCC_ONE;
    end

    // Hit buffer storage; contents are not cleared by reset.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= HIT_DATA;
    end

    // Pointers, occupancy, status flags and the saturating drop counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            TOKEN    <= 1'b0;
            HIT_FULL <= 1'b0;
            LOST_CNT <= 8'd0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            occ      <= occ_next;
            TOKEN    <= (occ_next != '0);
            HIT_FULL <= (occ_next == OCC_FULL);
            if (do_drop && (LOST_CNT != 8'hFF))
                LOST_CNT <= LOST_CNT + 8'd1;
        end
    end

    // Readout FSM; DATA is the output stage of the shift register, so shreg holds the bits still to come.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            read_q  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            DATA    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            read_q <= READ;
            case (state)
                IDLE: begin
                    DATA <= 1'b0;
                    if (read_req && FREEZE) begin
                        state <= LOAD;
                        BUSY  <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg   <= load_word << 1;
                    DATA    <= load_word[DATA_WIDTH-1];
                    bit_cnt <= CNT_LAST;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DATA  <= 1'b0;
                    end else begin
                        DATA    <= shreg[DATA_WIDTH-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DATA  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mono_data_tx.sv
// Bench for mono_data_tx: randomized and directed stimulus checked against a queue-based transmit model.
// The model tracks the buffer as a queue and a readout as a busy countdown of DATA_WIDTH+1 cycles.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_mono_data_tx;
    localparam int W     = 26;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst, en, hit_wr, read, freeze;
    logic [W-1:0] hit_data;
    logic         TOKEN, DATA, HIT_FULL, BUSY;
    logic [7:0]   LOST_CNT;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [7:0]   m_lost;
    int           m_busy;
    logic         m_prev_read;
    logic [W-1:0] m_word;

    always #12.5 clk = ~clk;

    mono_data_tx #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .EN(en), .HIT_WR(hit_wr), .HIT_DATA(hit_data),
        .READ(read), .FREEZE(freeze), .TOKEN(TOKEN), .DATA(DATA),
        .HIT_FULL(HIT_FULL), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
    );

    // One clock: inputs are sampled at the rising edge, the model advances, then we wait for the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_lost      = 8'd0;
            m_busy      = 0;
            m_prev_read = 1'b0;
        end else begin
            if (m_busy == W + 1) begin
                if (mq.size() != 0) m_word = mq.pop_front();
                else                m_word = '0;
            end
            if (en && hit_wr) begin
                if (mq.size() < DEPTH) mq.push_back(hit_data);
                else if (m_lost != 8'd255) m_lost = m_lost + 8'd1;
            end
            if (m_busy != 0) m_busy = m_busy - 1;
            else if (read && !m_prev_read && freeze) m_busy = W + 1;
            m_prev_read = read;
        end
        @(negedge clk);
    endtask

    // Expected {TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT} from the model.
    function automatic logic [11:0] exp_outs();
        logic d;
        d = (m_busy >= 1 && m_busy <= W) ? m_word[m_busy-1] : 1'b0;
        return {mq.size() != 0, mq.size() == DEPTH, m_busy != 0, d, m_lost};
    endfunction

    // Pulse READ and run a full readout, capturing the serial bits while the model says they are on DATA.
    task automatic read_word(output logic [W-1:0] cap, output int busy_cycles);
        cap = '0;
        busy_cycles = 0;
        read = 1'b1;
        tick();
        read = 1'b0;
        if (BUSY) busy_cycles++;
        for (int i = 0; i < W + 1; i++) begin
            tick();
            if (BUSY) busy_cycles++;
            if (m_busy >= 1 && m_busy <= W) cap = {cap[W-2:0], DATA};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; hit_wr = 1'b1; read = 1'b1; freeze = 1'b1; hit_data = 26'h123_4567;
        do_reset();
        total++;
        if ({TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outs: got %h want 000", {TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT});
        end
        hit_wr = 1'b0; read = 1'b0; freeze = 1'b0;
        tick();
        total++;
        if ({TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT} !== exp_outs()) begin
            bad++;
            $display("FAIL reset_after: got %h want %h", {TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT}, exp_outs());
        end
    endtask

    task automatic test_single_hit();
        logic [W-1:0] cap;
        int           bc;
        do_reset();
        hit_wr = 1'b1; hit_data = 26'h2A5_5A5A;
        tick();
        hit_wr = 1'b0;
        total++;
        if (TOKEN !== 1'b1) begin
            bad++;
            $display("FAIL single_token_rise: got %b want 1", TOKEN);
        end
        freeze = 1'b1;
        read = 1'b1;
        tick();
        read = 1'b0;
        total++;
        if ({BUSY, DATA, TOKEN} !== 3'b101) begin
            bad++;
            $display("FAIL single_load_cycle: got busy/data/token %b want 101", {BUSY, DATA, TOKEN});
        end
        tick();
        total++;
        if ({BUSY, DATA, TOKEN} !== 3'b110) begin
            bad++;
            $display("FAIL single_first_bit: got busy/data/token %b want 110", {BUSY, DATA, TOKEN});
        end
        do_reset();
        hit_wr = 1'b1; hit_data = 26'h2A5_5A5A;
        tick();
        hit_wr = 1'b0;
        read_word(cap, bc);
        total++;
        if (cap !== 26'h2A5_5A5A) begin
            bad++;
            $display("FAIL single_word: got %h want 2a55a5a", cap);
        end
        total++;
        if (bc !== 27) begin
            bad++;
            $display("FAIL single_busy_len: got %0d want 27", bc);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] sent[$];
        logic [W-1:0] cap;
        int           bc;
        do_reset();
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hit_wr = 1'b1; hit_data = W'($urandom());
            sent.push_back(hit_data);
            tick();
        end
        hit_wr = 1'b0;
        total++;
        if ({HIT_FULL, LOST_CNT} !== {1'b1, 8'd4}) begin
            bad++;
            $display("FAIL overflow_flags: got full=%b lost=%0d want full=1 lost=4", HIT_FULL, LOST_CNT);
        end
        for (int i = 0; i < 16; i++) begin
            read_word(cap, bc);
            total++;
            if (cap !== sent[i]) begin
                bad++;
                $display("FAIL overflow_word%0d: got %h want %h", i, cap, sent[i]);
            end
        end
        total++;
        if ({TOKEN, HIT_FULL} !== 2'b00) begin
            bad++;
            $display("FAIL overflow_drained: got token/full %b want 00", {TOKEN, HIT_FULL});
        end
    endtask

    task automatic test_empty_read();
        logic [W-1:0] cap;
        int           bc;
        logic         tok_seen;
        do_reset();
        freeze = 1'b1;
        read_word(cap, bc);
        total++;
        if (cap !== '0 || bc !== 27) begin
            bad++;
            $display("FAIL empty_read: got word %h busy %0d want 0 and 27", cap, bc);
        end
        hit_wr = 1'b1; hit_data = 26'h3FF_FFFF;
        tick();
        hit_wr = 1'b0;
        tok_seen = TOKEN;
        read_word(cap, bc);
        total++;
        if (cap !== 26'h3FF_FFFF || tok_seen !== 1'b1) begin
            bad++;
            $display("FAIL empty_then_word: got %h tok %b want 3ffffff tok 1", cap, tok_seen);
        end
    endtask

    task automatic test_misuse();
        logic [W-1:0] a, b, cap;
        int           bc;
        int           busy_seen;
        do_reset();
        a = W'($urandom()); b = W'($urandom());
        hit_wr = 1'b1; hit_data = a; tick();
        hit_data = b; tick();
        hit_wr = 1'b0;
        freeze = 1'b0;
        read = 1'b1; tick(); read = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (BUSY) busy_seen++;
        end
        total++;
        if (busy_seen !== 0 || TOKEN !== 1'b1) begin
            bad++;
            $display("FAIL misuse_nofreeze: got busy %0d token %b want 0 and 1", busy_seen, TOKEN);
        end
        freeze = 1'b1;
        read = 1'b1; tick(); read = 1'b0;
        cap = '0;
        for (int i = 0; i < W + 1; i++) begin
            if (i == 12) read = 1'b1;
            else if (i == 13) read = 1'b0;
            tick();
            if (m_busy >= 1 && m_busy <= W) cap = {cap[W-2:0], DATA};
        end
        tick();
        total++;
        if (cap !== a || BUSY !== 1'b0 || TOKEN !== 1'b1) begin
            bad++;
            $display("FAIL misuse_second_read: got %h busy %b tok %b want %h 0 1", cap, BUSY, TOKEN, a);
        end
        read_word(cap, bc);
        total++;
        if (cap !== b || TOKEN !== 1'b0) begin
            bad++;
            $display("FAIL misuse_remaining: got %h tok %b want %h tok 0", cap, TOKEN, b);
        end
    endtask

    task automatic test_full_collision();
        logic [W-1:0] sent[$];
        logic [W-1:0] cap;
        int           bc;
        do_reset();
        freeze = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            hit_wr = 1'b1; hit_data = W'($urandom());
            sent.push_back(hit_data);
            tick();
        end
        hit_wr = 1'b0;
        read = 1'b1; tick(); read = 1'b0;
        hit_wr = 1'b1; hit_data = W'($urandom());
        sent.push_back(hit_data);
        tick();
        hit_wr = 1'b0;
        total++;
        if ({HIT_FULL, LOST_CNT} !== {1'b1, 8'd0}) begin
            bad++;
            $display("FAIL collision_flags: got full=%b lost=%0d want full=1 lost=0", HIT_FULL, LOST_CNT);
        end
        while (m_busy != 0) tick();
        for (int i = 1; i < DEPTH + 1; i++) begin
            read_word(cap, bc);
            total++;
            if (cap !== sent[i]) begin
                bad++;
                $display("FAIL collision_word%0d: got %h want %h", i, cap, sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] cap;
        logic [W-1:0] nw;
        int           bc;
        int           guard;
        do_reset();
        freeze = 1'b1;
        hit_wr = 1'b1; hit_data = W'($urandom()); tick();
        hit_data = W'($urandom()); tick();
        hit_wr = 1'b0;
        read = 1'b1; tick(); read = 1'b0;
        guard = 0;
        while (m_busy != 11 && guard < 40) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++;
            $display("FAIL midshift_reach: got guard %0d want below 40", guard);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if ({DATA, BUSY, TOKEN} !== 3'b000) begin
            bad++;
            $display("FAIL midshift_reset: got data/busy/token %b want 000", {DATA, BUSY, TOKEN});
        end
        nw = W'($urandom());
        hit_wr = 1'b1; hit_data = nw; tick();
        hit_wr = 1'b0;
        read_word(cap, bc);
        total++;
        if (cap !== nw || bc !== 27) begin
            bad++;
            $display("FAIL midshift_new_word: got %h busy %0d want %h 27", cap, bc, nw);
        end
    endtask

    task automatic test_saturation();
        logic tok_before;
        do_reset();
        freeze = 1'b0;
        hit_wr = 1'b1;
        for (int i = 0; i < DEPTH + 300; i++) begin
            hit_data = W'($urandom());
            tick();
        end
        total++;
        if (LOST_CNT !== 8'd255 || LOST_CNT !== m_lost) begin
            bad++;
            $display("FAIL saturate_lost: got %0d want 255", LOST_CNT);
        end
        en = 1'b0;
        tok_before = TOKEN;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        hit_wr = 1'b0;
        en = 1'b1;
        total++;
        if ({tok_before, TOKEN, LOST_CNT} !== {1'b1, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL en_low_ignored: got tokbefore %b tok %b lost %0d want 1 0 0", tok_before, TOKEN, LOST_CNT);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            en       = ($urandom_range(0, 9) != 0);
            hit_wr   = ($urandom_range(0, 9) < 4);
            hit_data = W'($urandom());
            read     = ($urandom_range(0, 4) == 0);
            freeze   = ($urandom_range(0, 9) < 7);
            tick();
            total++;
            if ({TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT} !== exp_outs()) begin
                bad++;
                $display("FAIL random_cycle%0d: got %h want %h", i, {TOKEN, HIT_FULL, BUSY, DATA, LOST_CNT}, exp_outs());
            end
        end
        rst = 1'b0; en = 1'b1; hit_wr = 1'b0; read = 1'b0;
    endtask

    initial begin
        m_lost = 8'd0; m_busy = 0; m_prev_read = 1'b0; m_word = '0;
        rst = 1'b1; en = 1'b1; hit_wr = 1'b0; read = 1'b0; freeze = 1'b0; hit_data = '0;
        @(negedge clk);
        test_reset();
        test_single_hit();
        test_overflow();
        test_empty_read();
        test_misuse();
        test_full_collision();
        test_reset_mid_shift();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
